instr_buf_fifo: RTL and testbench

Parametrised instruction buffer for the MPU front end, replacing the fixed single-depth instruction buffer. Accepts instruction words from the host and presents them first-word-fall-through to the MPU decoder. Adds occupancy count, programmable almost-full/almost-empty levels, flush, sticky error flags, and a mark/rewind mechanism so the decoder can replay an instruction loop (e.g. per-token attention kernels) without the host re-sending it.

---
 rtl/mpu_pkg.sv | 19 +
 rtl/instr_buf_ram.sv | 48 ++++
 rtl/instr_buf_fifo.sv | 206 ++++++++++++++++++++
 tb/tb_instr_buf_fifo.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mpu_pkg.sv
// -----------------------------------------------------------------------------
// mpu_pkg
// Shared definitions for the MPU front end: instruction word width, the word
// type used between the instruction buffer and the decoder, and the default
// instruction buffer geometry and watermark levels.
// -----------------------------------------------------------------------------
package mpu_pkg;

   // Instruction word width seen by the decoder.
   localparam int MPU_DW = 13;

   // Default instruction buffer geometry and watermarks.
   localparam int MPU_BUF_DEPTH  = 16;
   localparam int MPU_BUF_AF_LVL = MPU_BUF_DEPTH - 2;
   localparam int MPU_BUF_AE_LVL = 2;

   typedef logic [MPU_DW-1:0] instr_word_t;

endpackage : mpu_pkg

// File: rtl/instr_buf_ram.sv
// -----------------------------------------------------------------------------
// instr_buf_ram
// DEPTH x DW register array backing the instruction buffer. One synchronous
// write port, one asynchronous (combinational) read port so the head word can
// be presented first-word-fall-through. Contents clear on reset.
//
// Ports
//   clk      in   clock, rising edge
//   rst_n    in   asynchronous active-low reset, clears every entry
//   we_i     in   write enable
//   waddr_i  in   write address (AW bits)
//   wdata_i  in   write data (DW bits)
//   raddr_i  in   read address (AW bits)
//   rdata_o  out  read data (DW bits), combinational from raddr_i
// -----------------------------------------------------------------------------
module instr_buf_ram
   import mpu_pkg::*;
#(
   parameter int DW    = MPU_DW,
   parameter int DEPTH = MPU_BUF_DEPTH,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [DW-1:0] wdata_i,
   input  logic [AW-1:0] raddr_i,
   output logic [DW-1:0] rdata_o
);

   logic [DW-1:0] mem_q [DEPTH];

   // NOTE: the array is reset because the head word must read as zero after
   // reset; a memory without reset would leave rd_data undefined until written.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule : instr_buf_ram

// File: rtl/instr_buf_fifo.sv
// -----------------------------------------------------------------------------
// instr_buf_fifo
// First-word-fall-through instruction buffer between the host and the MPU
// decoder. Provides occupancy count, almost-full/almost-empty watermarks,
// synchronous flush, sticky overflow/underflow flags, and a mark/rewind
// mechanism so the decoder can replay an instruction loop from a saved head
// position. Entries between the mark and the head stay protected from
// overwrite while the mark is held.
//
// Ports
//   clk           in   clock, rising edge
//   rst_n         in   asynchronous active-low reset
//   flush         in   synchronous clear of contents and mark
//   wr_en         in   push request
//   wr_data       in   instruction word to push
//   full          out  no free slot (counting mark-protected entries)
//   almost_full   out  occupied >= AF_LVL
//   rd_en         in   pop request
//   rd_data       out  head word, valid while empty = 0
//   empty         out  no readable entry
//   almost_empty  out  count <= AE_LVL
//   count         out  readable entries, 0..DEPTH
//   mark          in   save current head position as loop start
//   mark_clr      in   release saved position
//   rewind        in   restore read pointer to the saved position
//   mark_valid    out  a mark is held
//   ovf           out  sticky: write attempted while full
//   udf           out  sticky: read while empty, or rewind without mark
//   err_clr       in   clear ovf/udf
// -----------------------------------------------------------------------------
module instr_buf_fifo
   import mpu_pkg::*;
#(
   parameter int DW     = MPU_DW,
   parameter int DEPTH  = MPU_BUF_DEPTH,
   parameter int AF_LVL = DEPTH - 2,
   parameter int AE_LVL = MPU_BUF_AE_LVL
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      flush,
   input  logic                      wr_en,
   input  logic [DW-1:0]             wr_data,
   output logic                      full,
   output logic                      almost_full,
   input  logic                      rd_en,
   output logic [DW-1:0]             rd_data,
   output logic                      empty,
   output logic                      almost_empty,
   output logic [$clog2(DEPTH):0]    count,
   input  logic                      mark,
   input  logic                      mark_clr,
   input  logic                      rewind,
   output logic                      mark_valid,
   output logic                      ovf,
   output logic                      udf,
   input  logic                      err_clr
);

   localparam int AW = $clog2(DEPTH);

   // Thresholds sized to the pointer width so all comparisons are width-matched.
   localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
   localparam logic [AW:0] AF_W    = (AW+1)'(AF_LVL);
   localparam logic [AW:0] AE_W    = (AW+1)'(AE_LVL);
   localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

   // Pointers carry one extra wrap bit so full (difference == DEPTH) and
   // empty (difference == 0) are distinguishable.
   logic [AW:0] wr_ptr_q, wr_ptr_d;
   logic [AW:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0] mark_ptr_q, mark_ptr_d;
   logic        mark_valid_q, mark_valid_d;
   logic        ovf_q, ovf_d;
   logic        udf_q, udf_d;

   logic [AW:0] base_ptr;
   logic [AW:0] occupied;
   logic [AW:0] rd_count;
   logic        full_w;
   logic        empty_w;
   logic        wr_accept;

   // ---------------------------------------------------------------------------
   // Flags and count: purely from registered pointers, never from requests.
   // While a mark is held the oldest protected entry is at the mark, so the
   // free-space calculation starts there instead of at the head.
   // ---------------------------------------------------------------------------
   assign base_ptr = mark_valid_q ? mark_ptr_q : rd_ptr_q;
   assign occupied = wr_ptr_q - base_ptr;
   assign rd_count = wr_ptr_q - rd_ptr_q;
   assign full_w   = (occupied == DEPTH_W);
   assign empty_w  = (rd_count == '0);

   assign full         = full_w;
   assign almost_full  = (occupied >= AF_W);
   assign empty        = empty_w;
   assign almost_empty = (rd_count <= AE_W);
   assign count        = rd_count;
   assign mark_valid   = mark_valid_q;
   assign ovf          = ovf_q;
   assign udf          = udf_q;

   // Flush blocks the write so a word pushed alongside flush is not kept.
   assign wr_accept = wr_en && !full_w && !flush;

   // ---------------------------------------------------------------------------
   // Next-state logic.
   // Priority: flush > rewind > (mark_clr then mark) > rd_en. Writes run
   // alongside read/mark operations.
   // ---------------------------------------------------------------------------
   always_comb begin
      logic ovf_set;
      logic udf_set;

      // NOTE: every variable assigned here gets a default first so no path
      // leaves one unassigned, which would otherwise infer a latch.
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      mark_ptr_d   = mark_ptr_q;
      mark_valid_d = mark_valid_q;
      ovf_set      = 1'b0;
      udf_set      = 1'b0;

      if (flush) begin
         // Errors raised alongside a flush are deliberately not flagged.
         wr_ptr_d     = '0;
         rd_ptr_d     = '0;
         mark_ptr_d   = '0;
         mark_valid_d = 1'b0;
      end else begin
         if (wr_accept) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
         end else if (wr_en) begin
            ovf_set = 1'b1;
         end

         if (rewind) begin
            // A rewind cycle ignores rd_en, mark and mark_clr; the mark stays held.
            if (mark_valid_q) begin
               rd_ptr_d = mark_ptr_q;
            end else begin
               udf_set = 1'b1;
            end
         end else begin
            if (mark_clr) begin
               mark_valid_d = 1'b0;
            end
            // Mark captures the pre-pop head so the current word is the loop start.
            if (mark) begin
               mark_ptr_d   = rd_ptr_q;
               mark_valid_d = 1'b1;
            end
            if (rd_en) begin
               if (!empty_w) begin
                  rd_ptr_d = rd_ptr_q + PTR_ONE;
               end else begin
                  udf_set = 1'b1;
               end
            end
         end
      end

      // A new error in the clearing cycle wins over err_clr.
      ovf_d = ovf_set || (ovf_q && !err_clr);
      udf_d = udf_set || (udf_q && !err_clr);
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         mark_ptr_q   <= '0;
         mark_valid_q <= 1'b0;
         ovf_q        <= 1'b0;
         udf_q        <= 1'b0;
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         mark_ptr_q   <= mark_ptr_d;
         mark_valid_q <= mark_valid_d;
         ovf_q        <= ovf_d;
         udf_q        <= udf_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Storage: written at the write pointer, read combinationally at the head.
   // ---------------------------------------------------------------------------
   instr_buf_ram #(
      .DW    (DW),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_ram (
      .clk     (clk),
      .rst_n   (rst_n),
      .we_i    (wr_accept),
      .waddr_i (wr_ptr_q[AW-1:0]),
      .wdata_i (wr_data),
      .raddr_i (rd_ptr_q[AW-1:0]),
      .rdata_o (rd_data)
   );

endmodule : instr_buf_fifo

// File: tb/tb_instr_buf_fifo.sv
// -----------------------------------------------------------------------------
// tb_instr_buf_fifo
// Directed bench for instr_buf_fifo with DEPTH=8. Each pop pushes its expected
// word into a queue; a monitor on the falling edge compares every accepted pop
// against the queue head. Flags and count are checked directly after edges.
// The word width is widened to 16 bits so the instruction values used below
// are stored without truncation.
// -----------------------------------------------------------------------------
module tb_instr_buf_fifo;

   localparam int TB_DW    = 16;
   localparam int TB_DEPTH = 8;
   localparam int TB_AW    = $clog2(TB_DEPTH);

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             flush = 1'b0;
   logic             wr_en = 1'b0;
   logic [TB_DW-1:0] wr_data = '0;
   logic             full;
   logic             almost_full;
   logic             rd_en = 1'b0;
   logic [TB_DW-1:0] rd_data;
   logic             empty;
   logic             almost_empty;
   logic [TB_AW:0]   count;
   logic             mark = 1'b0;
   logic             mark_clr = 1'b0;
   logic             rewind = 1'b0;
   logic             mark_valid;
   logic             ovf;
   logic             udf;
   logic             err_clr = 1'b0;

   int n_tests = 0;
   int n_fail  = 0;

   logic [TB_DW-1:0] exp_q [$];
   logic [TB_DW-1:0] mon_exp;

   always #5 clk = ~clk;

   instr_buf_fifo #(
      .DW     (TB_DW),
      .DEPTH  (TB_DEPTH),
      .AF_LVL (TB_DEPTH - 2),
      .AE_LVL (2)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .flush        (flush),
      .wr_en        (wr_en),
      .wr_data      (wr_data),
      .full         (full),
      .almost_full  (almost_full),
      .rd_en        (rd_en),
      .rd_data      (rd_data),
      .empty        (empty),
      .almost_empty (almost_empty),
      .count        (count),
      .mark         (mark),
      .mark_clr     (mark_clr),
      .rewind       (rewind),
      .mark_valid   (mark_valid),
      .ovf          (ovf),
      .udf          (udf),
      .err_clr      (err_clr)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Monitor: an accepted pop at the coming edge presents its word now.
   always @(negedge clk) begin
      if (rst_n && rd_en && !empty) begin
         n_tests++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL pop_unexpected: got %0d, expected no pop", rd_data);
         end else begin
            mon_exp = exp_q.pop_front();
            if (rd_data !== mon_exp) begin
               n_fail++;
               $display("FAIL pop_data: got %0d, expected %0d", rd_data, mon_exp);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write(input logic [TB_DW-1:0] d);
      wr_en = 1'b1; wr_data = d;
      tick();
      wr_en = 1'b0;
   endtask

   task automatic pop(input logic [TB_DW-1:0] e);
      exp_q.push_back(e);
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
   endtask

   task automatic pulse_err_clr();
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
   endtask

   initial begin
      #100000;
      n_fail++;
      $display("FAIL watchdog: got timeout, expected completion");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $fatal(1, "watchdog");
   end

   initial begin
      // ---------------- reset values ----------------
      #3;
      check("rst_empty", empty, 1);
      check("rst_almost_empty", almost_empty, 1);
      check("rst_full", full, 0);
      check("rst_almost_full", almost_full, 0);
      check("rst_count", count, 0);
      check("rst_mark_valid", mark_valid, 0);
      check("rst_ovf", ovf, 0);
      check("rst_udf", udf, 0);
      check("rst_rd_data", rd_data, 0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // ---------------- basic ordering ----------------
      write(16'd2574);
      check("first_word_fwft", rd_data, 2574);
      check("first_word_empty", empty, 0);
      write(16'd7456);
      write(16'd12652);
      write(16'd15842);
      check("four_count", count, 4);
      check("four_almost_empty", almost_empty, 0);
      pop(16'd2574);
      pop(16'd7456);
      pop(16'd12652);
      check("three_popped_not_empty", empty, 0);
      pop(16'd15842);
      check("four_popped_empty", empty, 1);
      check("four_popped_count", count, 0);

      // ---------------- fill, overflow, watermarks ----------------
      for (int i = 0; i < 9; i++) begin
         write(16'(100 + i));
         if (i == 4) check("af_at_5", almost_full, 0);
         if (i == 5) check("af_at_6", almost_full, 1);
         if (i == 6) check("full_at_7", full, 0);
         if (i == 7) begin
            check("full_at_8", full, 1);
            check("ovf_before_drop", ovf, 0);
         end
      end
      check("ovf_after_drop", ovf, 1);
      check("count_after_drop", count, 8);
      for (int i = 0; i < 8; i++) pop(16'(100 + i));
      check("drain_empty", empty, 1);
      pulse_err_clr();
      check("ovf_cleared", ovf, 0);

      // ---------------- underflow ----------------
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      check("udf_set", udf, 1);
      check("udf_count", count, 0);
      check("udf_rd_data_kept", rd_data, 100);
      pulse_err_clr();
      check("udf_cleared", udf, 0);

      // Read+write while empty: write lands, read rejected.
      rd_en = 1'b1; wr_en = 1'b1; wr_data = 16'd555;
      tick();
      rd_en = 1'b0; wr_en = 1'b0;
      check("rw_empty_count", count, 1);
      check("rw_empty_udf", udf, 1);
      check("rw_empty_data", rd_data, 555);
      pop(16'd555);
      pulse_err_clr();

      // Read+write while full: read succeeds, write rejected.
      for (int i = 0; i < 8; i++) write(16'(300 + i));
      exp_q.push_back(16'd300);
      rd_en = 1'b1; wr_en = 1'b1; wr_data = 16'd777;
      tick();
      rd_en = 1'b0; wr_en = 1'b0;
      check("rw_full_count", count, 7);
      check("rw_full_ovf", ovf, 1);
      check("rw_full_full", full, 0);
      for (int i = 1; i < 8; i++) pop(16'(300 + i));
      check("rw_full_drained", empty, 1);
      pulse_err_clr();

      // ---------------- mark / rewind ----------------
      write(16'd2574);
      write(16'd7456);
      write(16'd12652);
      mark = 1'b1;
      tick();
      mark = 1'b0;
      check("mark_valid_set", mark_valid, 1);
      pop(16'd2574);
      pop(16'd7456);
      pop(16'd12652);
      check("loop_consumed_empty", empty, 1);
      rewind = 1'b1;
      tick();
      rewind = 1'b0;
      check("rewind_rd_data", rd_data, 2574);
      check("rewind_count", count, 3);
      check("rewind_mark_valid", mark_valid, 1);
      pop(16'd2574);
      pop(16'd7456);
      pop(16'd12652);
      mark_clr = 1'b1;
      tick();
      mark_clr = 1'b0;
      check("mark_cleared", mark_valid, 0);

      rewind = 1'b1;
      tick();
      rewind = 1'b0;
      check("rewind_no_mark_udf", udf, 1);
      check("rewind_no_mark_count", count, 0);
      pulse_err_clr();

      // mark and mark_clr together: mark wins.
      mark = 1'b1; mark_clr = 1'b1;
      tick();
      mark = 1'b0; mark_clr = 1'b0;
      check("mark_beats_clr", mark_valid, 1);

      // ---------------- mark-protected entries ----------------
      for (int i = 0; i < 8; i++) write(16'(200 + i));
      check("prot_full", full, 1);
      pop(16'd200);
      pop(16'd201);
      check("prot_count", count, 6);
      check("prot_still_full", full, 1);
      write(16'd999);
      check("prot_write_ovf", ovf, 1);
      check("prot_write_count", count, 6);
      mark_clr = 1'b1;
      tick();
      mark_clr = 1'b0;
      check("prot_released_full", full, 0);
      check("prot_released_af", almost_full, 1);
      write(16'd999);
      check("prot_write_ok", count, 7);

      // ---------------- flush ----------------
      mark = 1'b1;
      tick();
      mark = 1'b0;
      flush = 1'b1; wr_en = 1'b1; wr_data = 16'd4242;
      tick();
      flush = 1'b0; wr_en = 1'b0;
      check("flush_count", count, 0);
      check("flush_empty", empty, 1);
      check("flush_mark_valid", mark_valid, 0);
      check("flush_ovf_kept", ovf, 1);
      check("flush_full", full, 0);

      // ---------------- async reset mid-write ----------------
      write(16'd11);
      write(16'd22);
      mark = 1'b1;
      tick();
      mark = 1'b0;
      wr_en = 1'b1; wr_data = 16'd33;
      #2;
      rst_n = 1'b0;
      #1;
      wr_en = 1'b0;
      check("arst_count", count, 0);
      check("arst_empty", empty, 1);
      check("arst_full", full, 0);
      check("arst_almost_empty", almost_empty, 1);
      check("arst_mark_valid", mark_valid, 0);
      check("arst_ovf", ovf, 0);
      check("arst_rd_data", rd_data, 0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      check("post_rst_empty", empty, 1);

      check("scoreboard_drained", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_instr_buf_fifo
